// File: rtl/clkgen_pkg.sv
// Shared definitions for the DCM programming sequencer: FSM states, frame preambles and frame length.
package clkgen_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_GAP1,
    ST_LOAD_M,
    ST_GAP2,
    ST_GO,
    ST_WAIT_DONE,
    ST_WAIT_LOCK,
    ST_TO_RST,
    ST_WD_RST
  } state_t;

  // Preambles are sent LSB first: D frame starts 1,0 and M frame starts 1,1.
  localparam logic [1:0] PRE_D     = 2'b01;
  localparam logic [1:0] PRE_M     = 2'b11;
  localparam int         FRAME_LEN = 10;
  localparam int         GAP_LEN   = 2;

  function automatic logic [FRAME_LEN-1:0] make_frame(input logic [1:0] pre, input logic [7:0] data);
    return {data, pre};
  endfunction

endpackage

// File: rtl/clkgen_prog_ser.sv
// 10-bit DCM program frame serialiser: 2-bit preamble then 8 data bits, LSB first, one bit per clk.
module clkgen_prog_ser
  import clkgen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] preamble,
  input  logic [7:0] data,
  output logic       sdata,
  output logic       busy
);

  logic [FRAME_LEN-1:0] frame;
  logic [FRAME_LEN-1:0] shreg;
  logic [3:0]           cnt;

  assign frame = make_frame(preamble, data);

  // The first bit appears in the cycle right after load, so busy spans exactly FRAME_LEN cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      sdata <= 1'b0;
      busy  <= 1'b0;
    end else if (load) begin
      sdata <= frame[0];
      shreg <= {1'b0, frame[FRAME_LEN-1:1]};
      cnt   <= 4'(FRAME_LEN - 1);
      busy  <= 1'b1;
    end else if (busy && cnt != 4'd0) begin
      sdata <= shreg[0];
      shreg <= {1'b0, shreg[FRAME_LEN-1:1]};
      cnt   <= cnt - 4'd1;
    end else begin
      sdata <= 1'b0;
      busy  <= 1'b0;
    end
  end

endmodule

// File: rtl/clkgen_prog.sv
// DCM dynamic-reprogramming sequencer: loads D and M frames, issues GO, waits for PROGDONE and LOCKED.
// Optional lock-loss watchdog with automatic replay is compiled in with CLKGEN_PROG_WATCHDOG_EN.
module clkgen_prog
  import clkgen_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RST_CYCLES     = 8,
  parameter int WD_CYCLES      = 1024
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] m_minus1,
  input  logic [7:0] d_minus1,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       dcm_progen,
  output logic       dcm_progdata,
  input  logic       dcm_progdone,
  input  logic       dcm_locked,
  output logic       dcm_rst,
  output logic       locked,
  output logic [7:0] relock_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + RST_CYCLES + FRAME_LEN + 1);

  if (TIMEOUT_CYCLES < 1 || RST_CYCLES < 1 || WD_CYCLES < 1) begin : g_bad_param
    $error("clkgen_prog: cycle-count parameters must be at least 1");
  end

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [1:0]    sync_meta;
  logic [1:0]    sync_q;
  logic          progdone_s;
  logic          go;
  logic [7:0]    last_m;
  logic [7:0]    last_d;
  logic          accept;
  logic          wd_fire;
  logic          replay_go;
  logic          ser_load;
  logic [1:0]    ser_pre;
  logic [7:0]    ser_data;
  logic          ser_sdata;
  logic          ser_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 2'b00;
      sync_q    <= 2'b00;
    end else begin
      sync_meta <= {dcm_locked, dcm_progdone};
      sync_q    <= sync_meta;
    end
  end

  assign progdone_s = sync_q[0];
  assign locked     = sync_q[1];

  assign cfg_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = cfg_ready && cfg_valid;
  assign replay_go  = (state == ST_WD_RST) && (tcnt == TW'(RST_CYCLES - 1));

  // A fresh request sends d_minus1 directly because last_d is only written on that same edge.
  always_comb begin
    ser_load = (accept && m_minus1 != 8'd0) || replay_go ||
               ((state == ST_GAP1) && (tcnt == TW'(GAP_LEN - 1)));
    ser_pre  = PRE_D;
    ser_data = last_d;
    if (state == ST_IDLE) begin
      ser_data = d_minus1;
    end else if (state == ST_GAP1) begin
      ser_pre  = PRE_M;
      ser_data = last_m;
    end
  end

  clkgen_prog_ser u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .preamble (ser_pre),
    .data     (ser_data),
    .sdata    (ser_sdata),
    .busy     (ser_busy)
  );

  assign dcm_progen   = ser_busy | go;
  assign dcm_progdata = ser_sdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tcnt    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      go      <= 1'b0;
      dcm_rst <= 1'b1;
      last_m  <= 8'd0;
      last_d  <= 8'd0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      go      <= 1'b0;
      dcm_rst <= 1'b0;
      tcnt    <= tcnt + 1'b1;
      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (accept) begin
            last_m <= m_minus1;
            last_d <= d_minus1;
            if (m_minus1 == 8'd0) err   <= 1'b1;
            else                  state <= ST_LOAD_D;
          end else if (wd_fire) begin
            state   <= ST_WD_RST;
            dcm_rst <= 1'b1;
          end
        end
        ST_LOAD_D: if (tcnt == TW'(FRAME_LEN - 1)) begin state <= ST_GAP1;  tcnt <= '0; end
        ST_GAP1:   if (tcnt == TW'(GAP_LEN - 1))   begin state <= ST_LOAD_M; tcnt <= '0; end
        ST_LOAD_M: if (tcnt == TW'(FRAME_LEN - 1)) begin state <= ST_GAP2;  tcnt <= '0; end
        ST_GAP2: begin
          if (tcnt == TW'(GAP_LEN - 1)) begin
            state <= ST_GO;
            tcnt  <= '0;
            go    <= 1'b1;
          end
        end
        ST_GO: begin
          state <= ST_WAIT_DONE;
          tcnt  <= '0;
        end
        ST_WAIT_DONE, ST_WAIT_LOCK: begin
          if (state == ST_WAIT_DONE && progdone_s) begin
            state <= ST_WAIT_LOCK;
            tcnt  <= '0;
          end else if (state == ST_WAIT_LOCK && locked) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state   <= ST_TO_RST;
            tcnt    <= '0;
            dcm_rst <= 1'b1;
          end
        end
        ST_TO_RST, ST_WD_RST: begin
          if (tcnt == TW'(RST_CYCLES - 1)) begin
            tcnt <= '0;
            if (state == ST_TO_RST) begin
              state <= ST_IDLE;
              err   <= 1'b1;
            end else begin
              state <= ST_LOAD_D;
            end
          end else begin
            dcm_rst <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CLKGEN_PROG_WATCHDOG_EN
  localparam int WW = $clog2(WD_CYCLES + 1);

  logic          armed;
  logic [WW-1:0] wd_cnt;
  logic          wd_cond;

  // Only an idle, previously-locked DCM is watched; a pending request always wins over a relock.
  assign wd_cond = (state == ST_IDLE) && !cfg_valid && armed && !locked;
  assign wd_fire = wd_cond && (wd_cnt == WW'(WD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed      <= 1'b0;
      wd_cnt     <= '0;
      relock_cnt <= 8'd0;
    end else begin
      if (done) armed <= 1'b1;
      if (wd_cond && !wd_fire) wd_cnt <= wd_cnt + 1'b1;
      else                     wd_cnt <= '0;
      if (wd_fire && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
    end
  end
`else
  assign wd_fire    = 1'b0;
  assign relock_cnt = 8'd0;
`endif

endmodule
